// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory requester.
// Converts an EX-stage LOAD/STORE into a single req/ack bus transaction,
// generates byte enables and lane-replicated store data, aligns and extends
// returned load data, and holds the pipeline while the access is in flight.
// A transaction that sees no acknowledge within MAX_WAIT request cycles is
// abandoned and reported on bus_err.

module mem_access #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] d_address,
    output logic        d_req,
    output logic        d_we,
    output logic [3:0]  d_be,
    output logic [31:0] d_data_write,
    input  logic        d_ack,
    input  logic [31:0] d_data_in,
    output logic [31:0] d_data_read,
    output logic        rdata_valid,
    output logic        stall,
    output logic        access_err,
    output logic        bus_err
);

    localparam int              CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   C_MAX     = CW'(MAX_WAIT);
    localparam logic [CW-1:0]   C_ONE     = CW'(1);
    localparam logic [6:0]      OP_LOAD   = 7'b0000011;
    localparam logic [6:0]      OP_STORE  = 7'b0100011;
    localparam logic [2:0]      F3_B      = 3'b000;
    localparam logic [2:0]      F3_H      = 3'b001;
    localparam logic [2:0]      F3_W      = 3'b010;
    localparam logic [2:0]      F3_BU     = 3'b100;
    localparam logic [2:0]      F3_HU     = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Legal size/sign code for the access kind, combined with alignment.
    function automatic logic f_legal(input logic       is_load,
                                     input logic [2:0] f3,
                                     input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] f_byte_en(input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << off;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the memory can pick any.
    function automatic logic [31:0] f_lanes(input logic [2:0]  f3,
                                            input logic [31:0] sd);
        logic [31:0] w;
        case (f3)
            F3_B:    w = {4{sd[7:0]}};
            F3_H:    w = {2{sd[15:0]}};
            F3_W:    w = sd;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Pull the addressed byte/half out of the raw word and extend it.
    function automatic logic [31:0] f_extract(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] raw);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_W:    res = raw;
            F3_BU:   res = {24'h00_0000, sh[7:0]};
            F3_HU:   res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_is_load;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;

    logic [31:0]   r_d_address;
    logic          r_d_req;
    logic          r_d_we;
    logic [3:0]    r_d_be;
    logic [31:0]   r_d_data_write;
    logic [31:0]   r_d_data_read;
    logic          r_rdata_valid;
    logic          r_access_err;
    logic          r_bus_err;

    logic          w_is_load;
    logic          w_is_store;
    logic          w_access;
    logic          w_legal;
    logic          w_start;
    logic          w_reject;
    logic          w_timeout;
    logic          w_term;
    logic          w_stall;

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    assign w_access   = ex_valid & (w_is_load | w_is_store);
    assign w_legal    = f_legal(w_is_load, funct3, addr[1:0]);
    assign w_start    = w_access & w_legal;
    assign w_reject   = w_access & ~w_legal;
    assign w_timeout  = (r_cnt == C_MAX);
    assign w_term     = d_ack | w_timeout;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept a legal access in IDLE, leave REQ on ack or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_term) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stall: raised in the accept cycle, held in REQ until the terminating cycle.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_stall = 1'b1;
                end else begin
                    w_stall = 1'b0;
                end
            end
            ST_REQ: begin
                if (w_term) begin
                    w_stall = 1'b0;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_stall = 1'b0;
        endcase
    end

    // Bus outputs, wait counter, captured access info and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_is_load      <= 1'b0;
            r_funct3       <= 3'b000;
            r_off          <= 2'b00;
            r_d_address    <= 32'h0000_0000;
            r_d_req        <= 1'b0;
            r_d_we         <= 1'b0;
            r_d_be         <= 4'b0000;
            r_d_data_write <= 32'h0000_0000;
            r_d_data_read  <= 32'h0000_0000;
            r_rdata_valid  <= 1'b0;
            r_access_err   <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            // Pulses default low; the branches below raise them for one cycle.
            r_rdata_valid <= 1'b0;
            r_access_err  <= 1'b0;
            r_bus_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt          <= C_ONE;
                        r_is_load      <= w_is_load;
                        r_funct3       <= funct3;
                        r_off          <= addr[1:0];
                        r_d_address    <= {addr[31:2], 2'b00};
                        r_d_req        <= 1'b1;
                        r_d_we         <= w_is_store;
                        r_d_be         <= w_is_store ? f_byte_en(funct3, addr[1:0]) : 4'b0000;
                        r_d_data_write <= w_is_store ? f_lanes(funct3, store_data) : 32'h0000_0000;
                    end else begin
                        r_access_err   <= w_reject;
                    end
                end
                ST_REQ: begin
                    if (d_ack) begin
                        r_d_req <= 1'b0;
                        r_d_we  <= 1'b0;
                        r_d_be  <= 4'b0000;
                        if (r_is_load) begin
                            r_d_data_read <= f_extract(r_funct3, r_off, d_data_in);
                            r_rdata_valid <= 1'b1;
                        end else begin
                            r_d_data_read <= r_d_data_read;
                        end
                    end else if (w_timeout) begin
                        r_d_req       <= 1'b0;
                        r_d_we        <= 1'b0;
                        r_d_be        <= 4'b0000;
                        r_bus_err     <= 1'b1;
                        r_d_data_read <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_d_req <= 1'b0;
                end
            endcase
        end
    end

    assign d_address    = r_d_address;
    assign d_req        = r_d_req;
    assign d_we         = r_d_we;
    assign d_be         = r_d_be;
    assign d_data_write = r_d_data_write;
    assign d_data_read  = r_d_data_read;
    assign rdata_valid  = r_rdata_valid;
    assign access_err   = r_access_err;
    assign bus_err      = r_bus_err;
    assign stall        = w_stall;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads of every size, stores, rejected
// accesses, request timeout and reset in the middle of a request.

module tb_mem_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] d_address;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_data_write;
    logic        d_ack;
    logic [31:0] d_data_in;
    logic [31:0] d_data_read;
    logic        rdata_valid;
    logic        stall;
    logic        access_err;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_access #(.MAX_WAIT(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .opcode       (opcode),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .d_address    (d_address),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_be         (d_be),
        .d_data_write (d_data_write),
        .d_ack        (d_ack),
        .d_data_in    (d_data_in),
        .d_data_read  (d_data_read),
        .rdata_valid  (rdata_valid),
        .stall        (stall),
        .access_err   (access_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [31:0] exp_rd);
        chk({tag, "_req"},  32'(d_req), 32'd0);
        chk({tag, "_we"},   32'(d_we), 32'd0);
        chk({tag, "_be"},   32'(d_be), 32'd0);
        chk({tag, "_rv"},   32'(rdata_valid), 32'd0);
        chk({tag, "_aerr"}, 32'(access_err), 32'd0);
        chk({tag, "_berr"}, 32'(bus_err), 32'd0);
        chk({tag, "_rd"},   d_data_read, exp_rd);
    endtask

    // Load whose ack arrives in the second request cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] data, input logic [31:0] exp);
        ex_valid = 1'b1; opcode = OP_LOAD; funct3 = f3; addr = a;
        #1;
        chk({tag, "_stall_issue"}, 32'(stall), 32'd1);
        tick();
        ex_valid = 1'b0;
        chk({tag, "_req"},  32'(d_req), 32'd1);
        chk({tag, "_addr"}, d_address, {a[31:2], 2'b00});
        chk({tag, "_be"},   32'(d_be), 32'd0);
        chk({tag, "_we"},   32'(d_we), 32'd0);
        #1;
        chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
        tick();
        d_ack = 1'b1; d_data_in = data;
        #1;
        chk({tag, "_stall_ack"}, 32'(stall), 32'd0);
        chk({tag, "_req_held"},  32'(d_req), 32'd1);
        tick();
        d_ack = 1'b0; d_data_in = 32'h0000_0000;
        chk({tag, "_req_drop"}, 32'(d_req), 32'd0);
        chk({tag, "_rv"},       32'(rdata_valid), 32'd1);
        chk({tag, "_data"},     d_data_read, exp);
        tick();
        chk({tag, "_rv_pulse"}, 32'(rdata_valid), 32'd0);
        chk({tag, "_data_hold"}, d_data_read, exp);
    endtask

    // Store acknowledged in its first request cycle; load result must not move.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [3:0] exp_be,
                            input logic [31:0] exp_dw, input logic [31:0] keep_rd);
        ex_valid = 1'b1; opcode = OP_STORE; funct3 = f3; addr = a; store_data = sd;
        #1;
        chk({tag, "_stall_issue"}, 32'(stall), 32'd1);
        tick();
        ex_valid = 1'b0; store_data = 32'h0000_0000;
        chk({tag, "_req"},  32'(d_req), 32'd1);
        chk({tag, "_we"},   32'(d_we), 32'd1);
        chk({tag, "_be"},   32'(d_be), 32'(exp_be));
        chk({tag, "_dw"},   d_data_write, exp_dw);
        chk({tag, "_addr"}, d_address, {a[31:2], 2'b00});
        d_ack = 1'b1;
        #1;
        chk({tag, "_stall_ack"}, 32'(stall), 32'd0);
        tick();
        d_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(d_req), 32'd0);
        chk({tag, "_rv"},       32'(rdata_valid), 32'd0);
        chk({tag, "_rd_keep"},  d_data_read, keep_rd);
        tick();
    endtask

    // Illegal or misaligned access: error pulse, no request, no stall.
    task automatic do_err(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a);
        ex_valid = 1'b1; opcode = op; funct3 = f3; addr = a; store_data = 32'h1234_5678;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        chk({tag, "_aerr"}, 32'(access_err), 32'd1);
        chk({tag, "_req"},  32'(d_req), 32'd0);
        tick();
        chk({tag, "_aerr_pulse"}, 32'(access_err), 32'd0);
        chk({tag, "_req_after"},  32'(d_req), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; opcode = 7'b0000000; funct3 = 3'b000;
        addr = 32'h0000_0000; store_data = 32'h0000_0000;
        d_ack = 1'b0; d_data_in = 32'h0000_0000;
        tick();
        tick();
        chk_idle_outputs("reset", 32'h0000_0000);
        chk("reset_addr", d_address, 32'h0000_0000);
        chk("reset_dw",   d_data_write, 32'h0000_0000);
        chk("reset_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;
        tick();

        do_load("lw",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lb",  3'b000, 32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_0102, 32'h8011_2233, 32'hFFFF_8011);
        do_load("lb1", 3'b000, 32'h0000_0101, 32'h8011_2233, 32'h0000_0022);
        do_load("lhu", 3'b101, 32'h0000_0102, 32'h8011_2233, 32'h0000_8011);

        do_store("sb", 3'b000, 32'h0000_0201, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8011);
        do_store("sh", 3'b001, 32'h0000_0202, 32'h0000_1234, 4'b1100, 32'h1234_1234, 32'h0000_8011);
        do_store("sw", 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0000_8011);

        do_err("lw_mis",  OP_LOAD,  3'b010, 32'h0000_0102);
        do_err("sh_mis",  OP_STORE, 3'b001, 32'h0000_0001);
        do_err("ld_f3",   OP_LOAD,  3'b011, 32'h0000_0100);
        do_err("sbu_f3",  OP_STORE, 3'b100, 32'h0000_0100);

        // Non-memory opcode: silently ignored.
        ex_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'b010; addr = 32'h0000_0102;
        #1;
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("alu_aerr", 32'(access_err), 32'd0);
        chk("alu_req",  32'(d_req), 32'd0);
        tick();

        // Timeout: 16 request cycles without ack.
        ex_valid = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; addr = 32'h0000_0300;
        tick();
        ex_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("to_req_wait",   32'(d_req), 32'd1);
            chk("to_stall_wait", 32'(stall), 32'd1);
            tick();
        end
        chk("to_req_last",   32'(d_req), 32'd1);
        chk("to_stall_last", 32'(stall), 32'd0);
        tick();
        chk("to_req_drop", 32'(d_req), 32'd0);
        chk("to_berr",     32'(bus_err), 32'd1);
        chk("to_rd_zero",  d_data_read, 32'h0000_0000);
        chk("to_rv",       32'(rdata_valid), 32'd0);
        chk("to_stall_rel", 32'(stall), 32'd0);
        d_ack = 1'b1; d_data_in = 32'h5555_AAAA;
        tick();
        d_ack = 1'b0;
        chk_idle_outputs("late_ack", 32'h0000_0000);
        tick();

        // Reset while a request is outstanding and ack arrives on the same edge.
        do_load("pre_rst", 3'b100, 32'h0000_0103, 32'h8011_2233, 32'h0000_0080);
        ex_valid = 1'b1; opcode = OP_STORE; funct3 = 3'b010; addr = 32'h0000_0400;
        store_data = 32'hFFFF_FFFF;
        tick();
        ex_valid = 1'b0;
        chk("rst_pre_req", 32'(d_req), 32'd1);
        opcode = OP_LOAD;
        d_ack = 1'b1; d_data_in = 32'h7777_7777; reset_n = 1'b0;
        tick();
        d_ack = 1'b0;
        chk_idle_outputs("mid_rst", 32'h0000_0000);
        chk("mid_rst_addr",  d_address, 32'h0000_0000);
        chk("mid_rst_dw",    d_data_write, 32'h0000_0000);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_rv", 32'(rdata_valid), 32'd0);

        // Normal operation resumes after reset.
        do_load("post_lw", 3'b010, 32'h0000_0010, 32'h0102_0304, 32'h0102_0304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
